// File: rtl/data_holder_pipe.sv
// data_holder_pipe
//
// Elastic holding pipeline: WIDTH-bit words move through DEPTH register
// stages under a valid/ready handshake. Each stage keeps its word while the
// stage ahead of it is occupied and not moving. Words compact forward into
// empty stages, and a full pipe whose output is accepted passes one word per
// cycle. A flush drops every word in flight. All state changes on the
// falling edge of clk.
//
// Parameters
//   WIDTH    data word width in bits (>= 1)
//   DEPTH    number of holding stages (>= 1)
//   CNT_W    width of the occupancy count (derived, leave at default)
//
// Ports
//   clk        clock, registers update on its falling edge
//   rst_n      synchronous active-low reset, sampled on the falling edge
//   in_data    upstream word
//   in_valid   upstream offers in_data
//   in_ready   pipe accepts a word this cycle
//   out_data   word held in the last stage
//   out_valid  last stage holds a word
//   out_ready  downstream accepts this cycle
//   flush      discard all held words
//   count      number of occupied stages

module data_holder_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  // Stage 0 is nearest the input, stage DEPTH-1 drives the output.
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  // adv[i]: stage i hands its word onward at the next edge.
  // rdy[i]: stage i can take a word at the next edge; rdy[DEPTH] is the
  // downstream ready so the chain needs no special case for the last stage.
  logic [DEPTH-1:0] adv;
  logic [DEPTH:0]   rdy;
  logic             take;

  // Ready chain, evaluated from the output stage back toward the input so
  // a full pipe that is being drained can still accept in the same cycle.
  always_comb begin
    adv        = '0;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = vld[DEPTH-1-k] & rdy[DEPTH-k];
      rdy[DEPTH-1-k] = ~vld[DEPTH-1-k] | adv[DEPTH-1-k];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign take      = in_valid & in_ready;
  assign out_data  = data[DEPTH-1];
  assign out_valid = vld[DEPTH-1] & ~flush;

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(vld[i]);
    end
  end

  // Flush clears only the valid bits; the data registers keep whatever they
  // held, as do stages that drop their word by advancing.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= take | (vld[0] & ~adv[0]);
      if (take) begin
        data[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= adv[i-1] | (vld[i] & ~adv[i]);
        if (adv[i-1]) begin
          data[i] <= data[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_holder_pipe.sv
module tb_data_holder_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_holder_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  // Reference model: words in flight, oldest first, each with the stage
  // position it occupies. A word moves one position forward when the slot
  // ahead is empty or is being vacated; the oldest word at the last position
  // leaves when downstream is ready.
  logic [WIDTH-1:0] q_data [$];
  int               q_pos  [$];
  logic [WIDTH-1:0] m_last = '0;
  bit               p_mv   [DEPTH];

  function automatic void plan();
    for (int k = 0; k < DEPTH; k++) p_mv[k] = 1'b0;
    for (int k = 0; k < q_pos.size(); k++) begin
      if (q_pos[k] == DEPTH - 1)                     p_mv[k] = out_ready;
      else if (k == 0 || q_pos[k-1] > q_pos[k] + 1)  p_mv[k] = 1'b1;
      else                                           p_mv[k] = p_mv[k-1];
    end
  endfunction

  function automatic bit m_in_ready();
    int n;
    plan();
    n = q_pos.size();
    if (flush) return 1'b0;
    if (n == 0) return 1'b1;
    return !(q_pos[n-1] == 0 && !p_mv[n-1]);
  endfunction

  function automatic bit m_out_valid();
    return q_pos.size() > 0 && q_pos[0] == DEPTH - 1 && !flush;
  endfunction

  function automatic void model_edge();
    bit accept;
    bit leave;
    if (!rst_n) begin
      q_data.delete();
      q_pos.delete();
      m_last = '0;
      return;
    end
    accept = in_valid && m_in_ready();
    if (flush) begin
      q_data.delete();
      q_pos.delete();
      return;
    end
    leave = q_pos.size() > 0 && q_pos[0] == DEPTH - 1 && p_mv[0];
    for (int k = 0; k < q_pos.size(); k++) begin
      if (p_mv[k] && q_pos[k] < DEPTH - 1) begin
        q_pos[k] = q_pos[k] + 1;
        if (q_pos[k] == DEPTH - 1) m_last = q_data[k];
      end
    end
    if (leave) begin
      void'(q_data.pop_front());
      void'(q_pos.pop_front());
    end
    if (accept) begin
      q_data.push_back(in_data);
      q_pos.push_back(0);
      if (DEPTH == 1) m_last = in_data;
    end
  endfunction

  // Outputs are sampled on the rising edge, midway between updating edges.
  task automatic sample();
    @(posedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      in_data = $urandom;
      sample();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_checks++;
      if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      if (c == 1) begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] words [4];
    int peak;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    peak = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c < 4) begin
        in_valid = 1'b1;
        in_data  = words[c];
      end
      sample();
      if (int'(count) > peak) peak = int'(count);
      if (c < 4) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      n_checks++;
      if (out_valid !== (c >= 3 && c <= 6)) begin
        n_fail++; $display("FAIL stream_out_valid c=%0d: got %b expected %b", c, out_valid, (c >= 3 && c <= 6));
      end
      if (c >= 3 && c <= 6) begin
        n_checks++;
        if (out_data !== words[c-3]) begin n_fail++; $display("FAIL stream_out_data c=%0d: got %h expected %h", c, out_data, words[c-3]); end
      end
      tick();
    end
    n_checks++;
    if (peak != 3) begin n_fail++; $display("FAIL stream_count_peak: got %0d expected 3", peak); end
  endtask

  task automatic test_backpressure();
    int idx;
    logic [WIDTH-1:0] got [$];
    idx = 0;
    idle_inputs();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + idx;
      sample();
      if (in_ready) idx++;
      tick();
    end
    n_checks++;
    if (idx != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
    in_valid = 1'b1;
    in_data  = 32'hA0 + idx;
    sample();
    n_checks++;
    if (count !== 2'd3) begin n_fail++; $display("FAIL bp_count_full: got %0d expected 3", count); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stalled: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
    if (out_valid) got.push_back(out_data);
    if (in_ready) idx++;
    tick();
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 5);
      in_data  = 32'hA0 + idx;
      sample();
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      tick();
    end
    n_checks++;
    if (got.size() != 5) begin n_fail++; $display("FAIL bp_emitted_count: got %0d expected 5", got.size()); end
    for (int k = 0; k < got.size() && k < 5; k++) begin
      n_checks++;
      if (got[k] !== 32'hA0 + k) begin n_fail++; $display("FAIL bp_order k=%0d: got %h expected %h", k, got[k], 32'hA0 + k); end
    end
  endtask

  task automatic test_bubble();
    logic [WIDTH-1:0] got [$];
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin in_valid = 1'b1; in_data = 32'h01; end
      if (c == 3) begin in_valid = 1'b1; in_data = 32'h02; end
      sample();
      if (c == 0 || c == 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready c=%0d: got %b expected 1", c, in_ready); end
      end
      tick();
    end
    idle_inputs();
    sample();
    n_checks++;
    if (count !== 2'd2) begin n_fail++; $display("FAIL bubble_count: got %0d expected 2", count); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h01) begin
      n_fail++; $display("FAIL bubble_head: got valid=%b data=%h expected valid=1 data=01", out_valid, out_data);
    end
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (out_valid) got.push_back(out_data);
      tick();
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== 32'h01 || got[1] !== 32'h02) begin
      n_fail++; $display("FAIL bubble_order: got %0d words first=%h expected 2 words 01,02", got.size(), (got.size() > 0) ? got[0] : '0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c < 2) begin in_valid = 1'b1; in_data = 32'hB0 + c; end
      sample();
      tick();
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hB2;
    out_ready = 1'b1;
    sample();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    tick();
    idle_inputs();
    sample();
    n_checks++;
    if (count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++;
    if (out_data !== 32'hB0) begin n_fail++; $display("FAIL flush_data_kept: got %h expected b0", out_data); end
    tick();
    for (int c = 0; c < 4; c++) begin
      sample();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_capture c=%0d: got %b expected 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c < 2) begin in_valid = 1'b1; in_data = 32'hC0 + c; end
      sample();
      tick();
    end
    rst_n     = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    sample();
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_checks++;
      if (count !== '0) begin n_fail++; $display("FAIL midrst_count c=%0d: got %0d expected 0", c, count); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid c=%0d: got %b expected 0", c, out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data c=%0d: got %h expected 0", c, out_data); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 99) >= 2);
      flush     = ($urandom_range(0, 99) < 5);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < 65);
      sample();
      n_checks++;
      if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %b expected %b", c, in_ready, m_in_ready()); end
      n_checks++;
      if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %b expected %b", c, out_valid, m_out_valid()); end
      n_checks++;
      if (out_data !== m_last) begin n_fail++; $display("FAIL rand_out_data c=%0d: got %h expected %h", c, out_data, m_last); end
      n_checks++;
      if (count !== CNT_W'(q_pos.size())) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, count, q_pos.size()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
